acq_sequencer: RTL and testbench
================================

ACQ_SEQUENCER -- requirements
Module: acq_sequencer

Interface
REQ-001 SHALL have parameter CNT_W, default 32, meaning the width of the period, gate and hold counters.
REQ-002 SHALL have parameter FRM_W, default 16, meaning the width of the frame counter.
REQ-003 SHALL have port CLK  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port RESET_N  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port TR  input  1  config write strobe, asynchronous to CLK.
REQ-006 SHALL have port ADDR  input  16  config register address, stable while TR is high.
REQ-007 SHALL have port DATA  input  32  config write data, stable while TR is high.
REQ-008 SHALL have port START  input  1  run request level from the launcher, asynchronous to CLK.
REQ-009 SHALL have port INIT_DDS  output  1  DDS init level.
REQ-010 SHALL have port RESET_N_PROBE  output  1  probe reset, active-low.
REQ-011 SHALL have port FRAME_GATE  output  1  acquisition gate.
REQ-012 SHALL have port FRAME_CNT  output  FRM_W  number of frames completed in the current run.
REQ-013 SHALL have port BUSY  output  1  high in INIT, SETTLE and RUN.
REQ-014 SHALL have port DONE  output  1  run-complete flag.

Function
REQ-015 SHALL pass TR and START each through a 2-flop synchronizer with rising-edge detect; a TR rising edge SHALL make the written value visible 3 CLK cycles later.
REQ-016 SHALL decode these write addresses: 120 frame_count[FRM_W-1:0], 121 frame_period, 122 gate_width, 123 init_hold, 124 settle, 125 control (bit0 = abort, self-clearing); other addresses SHALL be ignored.
REQ-017 SHALL accept writes to 120-124 only in IDLE or DONE; while BUSY, only 125 SHALL be accepted.
REQ-018 SHALL implement FSM IDLE -> INIT -> SETTLE -> RUN -> DONE -> IDLE.
REQ-019 IDLE: SHALL drive all outputs low; a synchronized START rise SHALL enter INIT and snapshot config registers 120-124 into working copies; a write in that same cycle SHALL update the register but not the snapshot.
REQ-020 INIT: SHALL hold INIT_DDS=1 and RESET_N_PROBE=0 for max(init_hold,1) cycles, then enter SETTLE.
REQ-021 SETTLE: SHALL hold RESET_N_PROBE=1 for settle cycles (0 = one cycle), then enter RUN, or DONE if frame_count=0.
REQ-022 RUN: SHALL time each frame as max(frame_period,1) cycles; FRAME_GATE SHALL be high for the first min(gate_width,period) cycles; gate_width=0 SHALL mean no gate.
REQ-023 RUN: FRAME_CNT SHALL increment on the last cycle of each frame; on reaching frame_count, the FSM SHALL enter DONE in the next cycle with FRAME_GATE low.
REQ-024 DONE: SHALL hold DONE=1, RESET_N_PROBE=1 and FRAME_CNT held until synchronized START is low, then enter IDLE and clear FRAME_CNT.
REQ-025 Abort write or START deassertion in INIT, SETTLE or RUN SHALL force IDLE next cycle, with all outputs low and FRAME_CNT=0.
REQ-026 If abort and the final frame end occur in the same cycle, abort SHALL win.
REQ-027 SHALL implement counters as unsigned with no wrap; FRAME_CNT SHALL saturate at its maximum.

Reset
REQ-028 RESET_N low SHALL asynchronously clear the FSM to IDLE, all config registers and synchronizers to 0, and all outputs to 0 (RESET_N_PROBE=0, i.e. probe held in reset).
REQ-029 Reset mid-run SHALL drop FRAME_GATE and INIT_DDS within the same cycle as reset assertion.

Structure
REQ-030 SHALL take the address constants 120-125, the state enum and the default widths from shared package acq_seq_pkg.
REQ-031 SHALL instantiate sub-module sync_edge (2-flop synchronizer with registered rising-edge pulse) twice, once for TR and once for START.

Verification
REQ-032 Bench SHALL check: write 120=3, 121=10, 122=4, 123=5, 124=2, then raise START -> INIT_DDS high 5 cycles, settle 2 cycles, 3 gates of 4 cycles every 10 cycles, FRAME_CNT 1,2,3, DONE=1.
REQ-033 Bench SHALL check: 120=0 with START rise -> INIT and SETTLE then DONE, no FRAME_GATE pulse, FRAME_CNT=0.
REQ-034 Bench SHALL check: 122=20 with 121=8 -> FRAME_GATE continuously high across all frames; 121=0 -> period of 1 cycle.
REQ-035 Bench SHALL check: abort write (125=1) during frame 2 -> IDLE next cycle, outputs 0, FRAME_CNT=0, later START rise reruns normally.
REQ-036 Bench SHALL check: write 121=50 while BUSY -> ignored for the run and register unchanged; START low in DONE -> IDLE, FRAME_CNT cleared.
REQ-037 Bench SHALL check: RESET_N pulse during RUN -> outputs 0 asynchronously and registers read back as defaults on the next run.

Source files
------------

// File: rtl/acq_seq_pkg.sv
// Shared constants and types for the acquisition sequencer.
package acq_seq_pkg;

    localparam int CNT_W_DEF = 32;
    localparam int FRM_W_DEF = 16;

    localparam logic [15:0] ADDR_FRAME_COUNT  = 16'd120;
    localparam logic [15:0] ADDR_FRAME_PERIOD = 16'd121;
    localparam logic [15:0] ADDR_GATE_WIDTH   = 16'd122;
    localparam logic [15:0] ADDR_INIT_HOLD    = 16'd123;
    localparam logic [15:0] ADDR_SETTLE       = 16'd124;
    localparam logic [15:0] ADDR_CONTROL      = 16'd125;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_INIT   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_RUN    = 3'd3,
        ST_DONE   = 3'd4
    } acq_state_e;

endpackage

// File: rtl/acq_sequencer_if.sv
// Synchronized config write bus between the sequencer core and its register file.
interface acq_sequencer_if;
    logic        wr_stb;
    logic [15:0] addr;
    logic [31:0] data;

    modport master (output wr_stb, addr, data);
    modport slave  (input  wr_stb, addr, data);
endinterface

// File: rtl/acq_sequencer_regs.sv
// Config register file: address decode, write lockout while busy, abort pulse.
module acq_sequencer_regs
    import acq_seq_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int FRM_W = FRM_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    acq_sequencer_if.slave   bus,
    input  logic             busy,
    output logic [FRM_W-1:0] frame_count,
    output logic [CNT_W-1:0] frame_period,
    output logic [CNT_W-1:0] gate_width,
    output logic [CNT_W-1:0] init_hold,
    output logic [CNT_W-1:0] settle,
    output logic             abort
);
    logic [FRM_W-1:0] frame_count_q, frame_count_d;
    logic [CNT_W-1:0] frame_period_q, frame_period_d;
    logic [CNT_W-1:0] gate_width_q, gate_width_d;
    logic [CNT_W-1:0] init_hold_q, init_hold_d;
    logic [CNT_W-1:0] settle_q, settle_d;

    // decode writes; timing registers are frozen while a run is in progress
    always_comb begin
        frame_count_d  = frame_count_q;
        frame_period_d = frame_period_q;
        gate_width_d   = gate_width_q;
        init_hold_d    = init_hold_q;
        settle_d       = settle_q;
        if (bus.wr_stb && !busy) begin
            case (bus.addr)
                ADDR_FRAME_COUNT:  frame_count_d  = bus.data[FRM_W-1:0];
                ADDR_FRAME_PERIOD: frame_period_d = bus.data[CNT_W-1:0];
                ADDR_GATE_WIDTH:   gate_width_d   = bus.data[CNT_W-1:0];
                ADDR_INIT_HOLD:    init_hold_d    = bus.data[CNT_W-1:0];
                ADDR_SETTLE:       settle_d       = bus.data[CNT_W-1:0];
                default:           ;
            endcase
        end
        // the strobe is a single-cycle pulse, so abort clears itself
        abort = bus.wr_stb && (bus.addr == ADDR_CONTROL) && bus.data[0];
    end

    // register storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_count_q  <= '0;
            frame_period_q <= '0;
            gate_width_q   <= '0;
            init_hold_q    <= '0;
            settle_q       <= '0;
        end else begin
            frame_count_q  <= frame_count_d;
            frame_period_q <= frame_period_d;
            gate_width_q   <= gate_width_d;
            init_hold_q    <= init_hold_d;
            settle_q       <= settle_d;
        end
    end

    assign frame_count  = frame_count_q;
    assign frame_period = frame_period_q;
    assign gate_width   = gate_width_q;
    assign init_hold    = init_hold_q;
    assign settle       = settle_q;
endmodule

// File: rtl/sync_edge.sv
// Two-flop synchronizer with a registered rising-edge pulse.
module sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic lvl,
    output logic rise
);
    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic rise_q, rise_d;

    // next values of the synchronizer chain; the pulse lines up with s2 going high
    always_comb begin
        s1_d   = din;
        s2_d   = s1_q;
        rise_d = s1_q & ~s2_q;
    end

    // synchronizer and pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            rise_q <= rise_d;
        end
    end

    assign lvl  = s2_q;
    assign rise = rise_q;
endmodule

// File: rtl/acq_sequencer.sv
// Acquisition sequencer: DDS init, probe settle, gated frame timing.
//
//   state  | meaning
//   IDLE   | all outputs low, waiting for a START rise
//   INIT   | INIT_DDS high, probe held in reset for max(init_hold,1) cycles
//   SETTLE | probe released, wait max(settle,1) cycles
//   RUN    | frames of max(period,1) cycles, gate for the first gate_width cycles
//   DONE   | DONE high, FRAME_CNT held until START drops
module acq_sequencer
    import acq_seq_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int FRM_W = FRM_W_DEF
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             TR,
    input  logic [15:0]      ADDR,
    input  logic [31:0]      DATA,
    input  logic             START,
    output logic             INIT_DDS,
    output logic             RESET_N_PROBE,
    output logic             FRAME_GATE,
    output logic [FRM_W-1:0] FRAME_CNT,
    output logic             BUSY,
    output logic             DONE
);
    logic             tr_lvl, tr_rise, start_lvl, start_rise;
    logic             busy, abort, stop_run;
    logic [FRM_W-1:0] cfg_fc;
    logic [CNT_W-1:0] cfg_fp, cfg_gw, cfg_ih, cfg_st;

    acq_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] gcnt_q, gcnt_d;
    logic [FRM_W-1:0] frm_cnt_q, frm_cnt_d, frm_inc;
    logic [FRM_W-1:0] fc_w_q, fc_w_d;
    logic [CNT_W-1:0] fp_w_q, fp_w_d, gw_w_q, gw_w_d, st_w_q, st_w_d;

    acq_sequencer_if cfg_bus ();

    sync_edge u_sync_tr (
        .clk   (CLK),
        .rst_n (RESET_N),
        .din   (TR),
        .lvl   (tr_lvl),
        .rise  (tr_rise)
    );

    sync_edge u_sync_start (
        .clk   (CLK),
        .rst_n (RESET_N),
        .din   (START),
        .lvl   (start_lvl),
        .rise  (start_rise)
    );

    // ADDR/DATA are stable for as long as TR is high, so sampling them raw is safe
    assign cfg_bus.wr_stb = tr_rise & tr_lvl;
    assign cfg_bus.addr   = ADDR;
    assign cfg_bus.data   = DATA;

    acq_sequencer_regs #(
        .CNT_W (CNT_W),
        .FRM_W (FRM_W)
    ) u_regs (
        .clk          (CLK),
        .rst_n        (RESET_N),
        .bus          (cfg_bus),
        .busy         (busy),
        .frame_count  (cfg_fc),
        .frame_period (cfg_fp),
        .gate_width   (cfg_gw),
        .init_hold    (cfg_ih),
        .settle       (cfg_st),
        .abort        (abort)
    );

    // down-counter load value: N cycles -> N-1, with zero treated as one cycle
    function automatic logic [CNT_W-1:0] load_of(input logic [CNT_W-1:0] v);
        return (v == '0) ? '0 : v - CNT_W'(1);
    endfunction

    // next-state, counters and working copies
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        gcnt_d    = gcnt_q;
        frm_cnt_d = frm_cnt_q;
        fc_w_d    = fc_w_q;
        fp_w_d    = fp_w_q;
        gw_w_d    = gw_w_q;
        st_w_d    = st_w_q;
        frm_inc   = (frm_cnt_q == '1) ? frm_cnt_q : frm_cnt_q + FRM_W'(1);
        stop_run  = abort || !start_lvl;
        case (state_q)
            ST_IDLE: begin
                frm_cnt_d = '0;
                if (start_rise) begin
                    state_d = ST_INIT;
                    fc_w_d  = cfg_fc;
                    fp_w_d  = cfg_fp;
                    gw_w_d  = cfg_gw;
                    st_w_d  = cfg_st;
                    cnt_d   = load_of(cfg_ih);
                end
            end
            ST_INIT: begin
                if (stop_run) begin
                    state_d   = ST_IDLE;
                    frm_cnt_d = '0;
                end else if (cnt_q == '0) begin
                    state_d = ST_SETTLE;
                    cnt_d   = load_of(st_w_q);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_SETTLE: begin
                if (stop_run) begin
                    state_d   = ST_IDLE;
                    frm_cnt_d = '0;
                end else if (cnt_q == '0) begin
                    state_d = (fc_w_q == '0) ? ST_DONE : ST_RUN;
                    cnt_d   = load_of(fp_w_q);
                    gcnt_d  = gw_w_q;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RUN: begin
                // abort is checked first so it beats a coincident final frame end
                if (stop_run) begin
                    state_d   = ST_IDLE;
                    frm_cnt_d = '0;
                end else begin
                    if (gcnt_q != '0) gcnt_d = gcnt_q - CNT_W'(1);
                    if (cnt_q == '0) begin
                        frm_cnt_d = frm_inc;
                        if (frm_inc >= fc_w_q) begin
                            state_d = ST_DONE;
                        end else begin
                            cnt_d  = load_of(fp_w_q);
                            gcnt_d = gw_w_q;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            ST_DONE: begin
                if (!start_lvl) begin
                    state_d   = ST_IDLE;
                    frm_cnt_d = '0;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                frm_cnt_d = '0;
            end
        endcase
    end

    // state, counters and working copies
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            gcnt_q    <= '0;
            frm_cnt_q <= '0;
            fc_w_q    <= '0;
            fp_w_q    <= '0;
            gw_w_q    <= '0;
            st_w_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            gcnt_q    <= gcnt_d;
            frm_cnt_q <= frm_cnt_d;
            fc_w_q    <= fc_w_d;
            fp_w_q    <= fp_w_d;
            gw_w_q    <= gw_w_d;
            st_w_q    <= st_w_d;
        end
    end

    // outputs decode straight from flops so reset drops them immediately
    assign busy          = (state_q == ST_INIT) || (state_q == ST_SETTLE) || (state_q == ST_RUN);
    assign BUSY          = busy;
    assign INIT_DDS      = (state_q == ST_INIT);
    assign RESET_N_PROBE = (state_q == ST_SETTLE) || (state_q == ST_RUN) || (state_q == ST_DONE);
    assign FRAME_GATE    = (state_q == ST_RUN) && (gcnt_q != '0);
    assign DONE          = (state_q == ST_DONE);
    assign FRAME_CNT     = frm_cnt_q;
endmodule

// File: tb/tb_acq_sequencer.sv
// Bench for acq_sequencer: directed scenarios plus randomized runs against a timeline model.
module tb_acq_sequencer;

    logic        CLK;
    logic        RESET_N;
    logic        START;
    logic        INIT_DDS, RESET_N_PROBE, FRAME_GATE, BUSY, DONE;
    logic [15:0] FRAME_CNT;
    logic [20:0] out_vec;

    int n_tests;
    int n_fail;

    // model of the config registers (index = address - 120) and run timeline
    logic [31:0] m_cfg [5];
    int m_h, m_s, m_p, m_n, m_g;

    acq_sequencer_if tb_bus ();

    acq_sequencer dut (
        .CLK           (CLK),
        .RESET_N       (RESET_N),
        .TR            (tb_bus.wr_stb),
        .ADDR          (tb_bus.addr),
        .DATA          (tb_bus.data),
        .START         (START),
        .INIT_DDS      (INIT_DDS),
        .RESET_N_PROBE (RESET_N_PROBE),
        .FRAME_GATE    (FRAME_GATE),
        .FRAME_CNT     (FRAME_CNT),
        .BUSY          (BUSY),
        .DONE          (DONE)
    );

    assign out_vec = {INIT_DDS, RESET_N_PROBE, FRAME_GATE, BUSY, DONE, FRAME_CNT};

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // snapshot the modelled registers into run parameters
    task automatic load_model();
        m_h = (m_cfg[3] == 0) ? 1 : int'(m_cfg[3]);
        m_s = (m_cfg[4] == 0) ? 1 : int'(m_cfg[4]);
        m_p = (m_cfg[1] == 0) ? 1 : int'(m_cfg[1]);
        m_n = int'({16'd0, m_cfg[0][15:0]});
        m_g = (int'(m_cfg[2]) < m_p) ? int'(m_cfg[2]) : m_p;
    endtask

    // expected {INIT_DDS, PROBE, GATE, BUSY, DONE, FRAME_CNT} t cycles after INIT entry
    function automatic logic [20:0] exp_at(input int t);
        int r;
        if (t < m_h) return {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0};
        if (t < m_h + m_s) return {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0};
        r = t - m_h - m_s;
        if (r < m_n * m_p)
            return {1'b0, 1'b1, ((r % m_p) < m_g), 1'b1, 1'b0, 16'(r / m_p)};
        return {1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'(m_n)};
    endfunction

    task automatic cfg_write(input logic [15:0] a, input logic [31:0] d);
        int idx;
        @(posedge CLK); #1;
        tb_bus.addr   = a;
        tb_bus.data   = d;
        tb_bus.wr_stb = 1'b1;
        repeat (5) @(posedge CLK);
        #1 tb_bus.wr_stb = 1'b0;
        repeat (3) @(posedge CLK);
        idx = int'(a) - 120;
        if (idx >= 0 && idx <= 4) m_cfg[idx] = d;
    endtask

    // one run: optional write at cycle stim_t, optional reset pulse at cycle rst_t
    task automatic run_seq(input int stim_t, input logic [15:0] stim_addr,
                           input logic [31:0] stim_data, input int rst_t);
        int          total;
        int          kill_t;
        logic [20:0] exp;
        load_model();
        total  = m_h + m_s + m_n * m_p;
        kill_t = -1;
        if (stim_t >= 0 && stim_addr == 16'd125 && stim_data[0] && stim_t + 2 < total)
            kill_t = stim_t + 3;
        @(posedge CLK); #1 START = 1'b1;
        repeat (2) @(posedge CLK);
        #1 check_eq("start_lat", 64'(BUSY), 64'd0);
        @(posedge CLK); #1;
        for (int t = 0; t < total + 3; t++) begin
            exp = (kill_t >= 0 && t >= kill_t) ? 21'd0 : exp_at(t);
            check_eq($sformatf("trace_t%0d", t), 64'(out_vec), 64'(exp));
            if (t == stim_t) begin
                tb_bus.addr   = stim_addr;
                tb_bus.data   = stim_data;
                tb_bus.wr_stb = 1'b1;
            end
            if (stim_t >= 0 && t == stim_t + 5) tb_bus.wr_stb = 1'b0;
            if (t == rst_t) begin
                #2 RESET_N = 1'b0;
                #1 check_eq("rst_async", 64'(out_vec), 64'd0);
                START         = 1'b0;
                tb_bus.wr_stb = 1'b0;
                for (int k = 0; k < 5; k++) m_cfg[k] = 32'd0;
                repeat (2) @(posedge CLK);
                #1 RESET_N = 1'b1;
                repeat (4) @(posedge CLK);
                #1;
                return;
            end
            @(posedge CLK); #1;
        end
        tb_bus.wr_stb = 1'b0;
        START         = 1'b0;
        repeat (2) @(posedge CLK);
        #1 check_eq("done_hold", 64'(out_vec), (kill_t >= 0) ? 64'd0 : 64'(exp_at(total)));
        @(posedge CLK);
        #1 check_eq("idle_after", 64'(out_vec), 64'd0);
        repeat (3) @(posedge CLK);
        #1;
    endtask

    initial begin
        int tot;
        int mode;
        n_tests       = 0;
        n_fail        = 0;
        RESET_N       = 1'b0;
        START         = 1'b0;
        tb_bus.wr_stb = 1'b0;
        tb_bus.addr   = 16'd0;
        tb_bus.data   = 32'd0;
        for (int k = 0; k < 5; k++) m_cfg[k] = 32'd0;

        repeat (3) @(posedge CLK);
        #1 check_eq("rst_outputs", 64'(out_vec), 64'd0);
        RESET_N = 1'b1;
        repeat (3) @(posedge CLK);

        // nominal run: 3 frames of 10, gate 4, init 5, settle 2
        cfg_write(16'd120, 32'd3);
        cfg_write(16'd121, 32'd10);
        cfg_write(16'd122, 32'd4);
        cfg_write(16'd123, 32'd5);
        cfg_write(16'd124, 32'd2);
        run_seq(-1, 16'd0, 32'd0, -1);

        // zero frames: straight from SETTLE to DONE
        cfg_write(16'd120, 32'd0);
        run_seq(-1, 16'd0, 32'd0, -1);

        // gate wider than period, then a one-cycle period
        cfg_write(16'd120, 32'd2);
        cfg_write(16'd121, 32'd8);
        cfg_write(16'd122, 32'd20);
        run_seq(-1, 16'd0, 32'd0, -1);
        cfg_write(16'd121, 32'd0);
        cfg_write(16'd120, 32'd5);
        run_seq(-1, 16'd0, 32'd0, -1);

        // abort during frame 2, then a clean rerun
        cfg_write(16'd120, 32'd3);
        cfg_write(16'd121, 32'd10);
        cfg_write(16'd122, 32'd4);
        cfg_write(16'd123, 32'd1);
        cfg_write(16'd124, 32'd0);
        run_seq(13, 16'd125, 32'd1, -1);
        run_seq(-1, 16'd0, 32'd0, -1);

        // abort seen on the last cycle of the final frame
        run_seq(29, 16'd125, 32'd1, -1);

        // period write while busy is dropped; next run still uses period 10
        run_seq(4, 16'd121, 32'd50, -1);
        run_seq(-1, 16'd0, 32'd0, -1);

        // writes to undecoded addresses change nothing
        cfg_write(16'd126, 32'd7);
        cfg_write(16'd119, 32'd9);
        run_seq(-1, 16'd0, 32'd0, -1);

        // randomized configurations with occasional abort or locked-out write
        for (int i = 0; i < 8; i++) begin
            cfg_write(16'd120, 32'($urandom_range(0, 4)));
            cfg_write(16'd121, 32'($urandom_range(0, 6)));
            cfg_write(16'd122, 32'($urandom_range(0, 8)));
            cfg_write(16'd123, 32'($urandom_range(0, 4)));
            cfg_write(16'd124, 32'($urandom_range(0, 3)));
            load_model();
            tot  = m_h + m_s + m_n * m_p;
            mode = int'($urandom_range(0, 2));
            if (mode == 1)
                run_seq(int'($urandom_range(0, tot)), 16'd125, 32'd1, -1);
            else if (mode == 2 && tot >= 3)
                run_seq(int'($urandom_range(0, tot - 3)), 16'(120 + $urandom_range(0, 4)),
                        32'($urandom_range(0, 50)), -1);
            else
                run_seq(-1, 16'd0, 32'd0, -1);
        end

        // reset pulse mid-RUN with the gate high, then a run on default registers
        cfg_write(16'd120, 32'd3);
        cfg_write(16'd121, 32'd10);
        cfg_write(16'd122, 32'd4);
        cfg_write(16'd123, 32'd5);
        cfg_write(16'd124, 32'd2);
        run_seq(-1, 16'd0, 32'd0, 10);
        run_seq(-1, 16'd0, 32'd0, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
